i2c_target_regif: RTL and testbench

//  I2C target (responder) for the I2CMaster frame: START, 7b addr+R/W, ACK, reg addr, ACK, data, ACK, STOP.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_target_regif.sv | 176 +++++++++++++++++
 tb/tb_i2c_target_regif.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// I2C target register bridge: shared constants.
// One-hot FSM encodings and bus widths used by the target and its bench.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int BYTE_W     = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [9:0] S_IDLE      = 10'b00_0000_0001;
    localparam logic [9:0] S_ADDR      = 10'b00_0000_0010;
    localparam logic [9:0] S_ADDR_ACK  = 10'b00_0000_0100;
    localparam logic [9:0] S_REG       = 10'b00_0000_1000;
    localparam logic [9:0] S_REG_ACK   = 10'b00_0001_0000;
    localparam logic [9:0] S_WDATA     = 10'b00_0010_0000;
    localparam logic [9:0] S_WDATA_ACK = 10'b00_0100_0000;
    localparam logic [9:0] S_RDATA     = 10'b00_1000_0000;
    localparam logic [9:0] S_RDATA_ACK = 10'b01_0000_0000;
    localparam logic [9:0] S_WAIT_STOP = 10'b10_0000_0000;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronises SCL/SDA into dclk and emits
// registered 1-cycle scl_rise/scl_fall/start/stop pulses plus the SDA level.
// Ports: dclk, rst (async high), scl_in, sda_in -> sda, scl_rise, scl_fall, start, stop.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic dclk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sr[SYNC_STAGES-1];
    assign sda_s = sda_sr[SYNC_STAGES-1];

    // Lines reset to the idle-high level so reset release cannot fake an edge.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            scl_sr   <= '1;
            sda_sr   <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sr   <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr   <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            sda      <= sda_s;
            scl_rise <= scl_s & ~scl_d;
            scl_fall <= ~scl_s & scl_d;
            start    <= ~sda_s & sda_d & scl_s;
            stop     <= sda_s & ~sda_d & scl_s;
        end
    end

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target bridging addr/reg/data frames onto a simple register port.
// Ports: dclk, rst, scl_in, sda_in, sda_oe, reg_addr, reg_wdata, reg_wr,
//        reg_rd, reg_rdata, busy, nack_seen.
module i2c_target_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR    = 7'h42,
    parameter int         DATA_WIDTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  dclk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [7:0]            reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  nack_seen
);

    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start;
    logic              stop;
    logic [9:0]        state;
    logic [3:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              rw;
    logic              rd_load;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .dclk     (dclk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            rd_load   <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            nack_seen <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            // Bus conditions override any bit activity in the same cycle.
            if (start) begin
                state     <= S_ADDR;
                bit_cnt   <= '0;
                busy      <= 1'b1;
                nack_seen <= 1'b0;
                sda_oe    <= 1'b0;
                rd_load   <= 1'b0;
            end else if (stop) begin
                state   <= S_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                rd_load <= 1'b0;
            end else if (rd_load) begin
                // reg_rdata answers the reg_rd strobe of the previous cycle.
                shreg   <= reg_rdata;
                sda_oe  <= ~reg_rdata[7];
                rd_load <= 1'b0;
            end else begin
                unique case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) rw <= sda;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == OWN_ADDR) begin
                                state  <= S_ADDR_ACK;
                                sda_oe <= 1'b1;
                            end else begin
                                state  <= S_WAIT_STOP;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            state   <= S_REG;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    S_REG: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_addr <= shreg;
                            state    <= S_REG_ACK;
                            sda_oe   <= 1'b1;
                        end
                    end
                    S_REG_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (rw) begin
                                reg_rd  <= 1'b1;
                                rd_load <= 1'b1;
                                state   <= S_RDATA;
                            end else begin
                                state <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) reg_wdata <= {shreg[6:0], sda};
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_wr <= 1'b1;
                            state  <= S_WDATA_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe   <= 1'b0;
                            reg_addr <= reg_addr + 8'd1;
                            bit_cnt  <= '0;
                            state    <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        // bit7 is already on the bus; falls 1..7 present bits 6..0.
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sda_oe <= 1'b0;
                                state  <= S_RDATA_ACK;
                            end else begin
                                sda_oe  <= ~shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise && sda == NACK) nack_seen <= 1'b1;
                        if (scl_fall) state <= S_WAIT_STOP;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: bus-level master model with
// scoreboard queues for SDA bits, register writes and register reads.
module tb_i2c_target_regif;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       dclk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h3C;
    logic       busy;
    logic       nack_seen;

    int total = 0;
    int passed = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        exp_bit[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 dclk = ~dclk;

    i2c_target_regif dut (
        .dclk      (dclk),
        .rst       (rst),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    always @(negedge dclk) begin
        if (!rst && reg_wr) begin
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0)
                chk("wr_addr_data", 32'({reg_addr, reg_wdata}),
                    32'(exp_wr.pop_front()));
        end
        if (!rst && reg_rd) begin
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0)
                chk("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
    end

    task automatic wq();
        repeat (Q) @(posedge dclk);
    endtask

    task automatic xfer(input logic b, output logic s);
        sda_m = b;
        wq();
        scl = 1'b1;
        wq();
        s = sda_line;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        sda_m = 1'b0;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        sda_m = 1'b1;
        wq();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer(b[i], s);
        exp_bit.push_back(ack);
        xfer(1'b1, s);
        chk("ack_bit", 32'(s), 32'(exp_bit.pop_front()));
    endtask

    task automatic recv_byte(input logic [7:0] d, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) exp_bit.push_back(d[i]);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, s);
            chk("rd_bit", 32'(s), 32'(exp_bit.pop_front()));
        end
        xfer(mack, s);
    endtask

    initial begin
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nack", 32'(nack_seen), 32'd0);
        chk("rst_regs", 32'({reg_addr, reg_wdata, reg_wr, reg_rd}), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge dclk);

        // single write
        exp_wr.push_back(16'h10A5);
        bus_start();
        chk("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h84, ACK);
        send_byte(8'h10, ACK);
        send_byte(8'hA5, ACK);
        bus_stop();
        wq();
        chk("wr_busy_end", 32'(busy), 32'd0);
        chk("wr_drained", 32'(exp_wr.size()), 32'd0);

        // wrong address
        bus_start();
        send_byte(8'h86, NACK);
        chk("wrong_state", 32'(dut.state), 32'(S_WAIT_STOP));
        send_byte(8'h10, NACK);
        chk("wrong_state2", 32'(dut.state), 32'(S_WAIT_STOP));
        bus_stop();
        wq();
        chk("wrong_idle", 32'(dut.state), 32'(S_IDLE));

        // read, master ACK
        exp_rd.push_back(8'h20);
        bus_start();
        send_byte(8'h85, ACK);
        send_byte(8'h20, ACK);
        recv_byte(8'h3C, ACK);
        bus_stop();
        wq();
        chk("rd_nack_clr", 32'(nack_seen), 32'd0);
        chk("rd_drained", 32'(exp_rd.size()), 32'd0);

        // read, master NACK
        exp_rd.push_back(8'h20);
        bus_start();
        send_byte(8'h85, ACK);
        send_byte(8'h20, ACK);
        recv_byte(8'h3C, NACK);
        chk("nack_set", 32'(nack_seen), 32'd1);
        bus_stop();
        wq();
        chk("nack_sticky", 32'(nack_seen), 32'd1);
        bus_start();
        chk("nack_cleared", 32'(nack_seen), 32'd0);
        bus_stop();
        wq();

        // burst write wrapping the register index
        exp_wr.push_back(16'hFF11);
        exp_wr.push_back(16'h0022);
        bus_start();
        send_byte(8'h84, ACK);
        send_byte(8'hFF, ACK);
        send_byte(8'h11, ACK);
        send_byte(8'h22, ACK);
        bus_stop();
        wq();
        chk("burst_drained", 32'(exp_wr.size()), 32'd0);
        chk("burst_addr", 32'(reg_addr), 32'h01);

        // repeated START, then reset in the middle of a read byte
        exp_rd.push_back(8'h40);
        bus_start();
        send_byte(8'h84, ACK);
        send_byte(8'h30, ACK);
        bus_start();
        chk("rs_state", 32'(dut.state), 32'(S_ADDR));
        send_byte(8'h85, ACK);
        send_byte(8'h40, ACK);
        chk("rs_rdata_state", 32'(dut.state), 32'(S_RDATA));
        chk("rs_bit7_driven", 32'(sda_oe), 32'd1);
        @(negedge dclk);
        rst = 1'b1;
        #1;
        chk("rst_async_oe", 32'(sda_oe), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge dclk);
        rst = 1'b0;
        wq();
        bus_start();
        chk("post_rst_addr", 32'(dut.state), 32'(S_ADDR));
        chk("post_rst_busy", 32'(busy), 32'd1);
        bus_stop();
        wq();
        chk("final_idle", 32'(dut.state), 32'(S_IDLE));
        chk("final_wr_q", 32'(exp_wr.size()), 32'd0);
        chk("final_rd_q", 32'(exp_rd.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
